// File: rtl/code_entry_display.sv
// Digit entry store with append/backspace/clear, per-digit active-low 7-seg output and
// a blinking cursor. Optional masked display is enabled by defining MASK_DISPLAY_EN.
module code_entry_display #(
  parameter int          NUM_DIGITS = 4,
  parameter int          CNT_W      = 4,
  parameter logic [24:0] BLINK_DIV  = 25'd25_000_000,
  parameter int          MASK_HOLD  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    sys_reset_n,
  input  logic                    clear_pulse,
  input  logic                    store_pulse,
  input  logic                    back_pulse,
  input  logic [3:0]              current_digit,
  output logic [4*NUM_DIGITS-1:0] entered_code,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    code_full,
  output logic                    entry_err,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BLINK_W = (BLINK_DIV > 25'd2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 25'd1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UNDER = 7'b1110111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Requests are single-cycle pulses sampled on the rising edge; when several are high
  // together only the highest priority one (clear > store > back) acts, the rest are dropped.
  logic [3:0]         dig_q [NUM_DIGITS];
  logic [CNT_W-1:0]   count_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_on_q;
  logic               err_q;
  logic               store_ok;
  logic               back_ok;

`ifdef MASK_DISPLAY_EN
  localparam int REVEAL_W = $clog2(MASK_HOLD + 1);
  logic [REVEAL_W-1:0] reveal_q;
`endif

  assign store_ok = (count_q < CNT_MAX) && (current_digit <= 4'd9);
  assign back_ok  = (count_q != '0);

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
      count_q     <= '0;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      err_q       <= 1'b0;
`ifdef MASK_DISPLAY_EN
      reveal_q    <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
`ifdef MASK_DISPLAY_EN
      if (reveal_q != '0) reveal_q <= reveal_q - REVEAL_W'(1);
`endif
      if (clear_pulse) begin
        for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
        count_q     <= '0;
        blink_cnt_q <= '0;
        phase_on_q  <= 1'b1;
`ifdef MASK_DISPLAY_EN
        reveal_q    <= '0;
`endif
      end else if (store_pulse) begin
        if (store_ok) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (CNT_W'(i) == count_q) dig_q[i] <= current_digit;
          count_q     <= count_q + CNT_W'(1);
          blink_cnt_q <= '0;
          phase_on_q  <= 1'b1;
`ifdef MASK_DISPLAY_EN
          reveal_q    <= REVEAL_W'(MASK_HOLD);
`endif
        end else begin
          err_q <= 1'b1;
        end
      end else if (back_pulse) begin
        if (back_ok) begin
          // Zero the vacated slot so entered_code never shows stale digits.
          for (int i = 0; i < NUM_DIGITS; i++)
            if (CNT_W'(i) == count_q - CNT_W'(1)) dig_q[i] <= '0;
          count_q     <= count_q - CNT_W'(1);
          blink_cnt_q <= '0;
          phase_on_q  <= 1'b1;
`ifdef MASK_DISPLAY_EN
          reveal_q    <= '0;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Position 0 (first entered) sits in the most significant nibble / 7-bit group.
  always_comb begin
    logic [6:0] seg;
    seg          = SEG_BLANK;
    entered_code = '0;
    hex_out      = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      entered_code[4*(NUM_DIGITS-1-i) +: 4] = dig_q[i];
      if (CNT_W'(i) < count_q) begin
        seg = glyph(dig_q[i]);
`ifdef MASK_DISPLAY_EN
        if (!((CNT_W'(i) == count_q - CNT_W'(1)) && (reveal_q != '0))) seg = SEG_DASH;
`endif
      end else if (CNT_W'(i) == count_q) begin
        seg = phase_on_q ? SEG_UNDER : SEG_BLANK;
      end else begin
        seg = SEG_BLANK;
      end
      hex_out[7*(NUM_DIGITS-1-i) +: 7] = seg;
    end
  end

  assign digit_count = count_q;
  assign code_full   = (count_q == CNT_MAX);
  assign entry_err   = err_q;

endmodule

// File: tb/tb_code_entry_display.sv
// Scoreboard bench for code_entry_display: directed scenarios then random requests,
// checked against a queue-based reference model of the entry and cursor behaviour.
module tb_code_entry_display;

  localparam int N         = 4;
  localparam int CW        = 4;
  localparam int BDIV      = 4;
  localparam int HOLD      = 3;

  typedef struct packed {
    logic [4*N-1:0] code;
    logic [CW-1:0]  cnt;
    logic           full;
    logic           err;
    logic [7*N-1:0] hex;
  } exp_t;
  localparam int W = $bits(exp_t);

  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

  logic           clk;
  logic           sys_reset_n;
  logic           clear_pulse;
  logic           store_pulse;
  logic           back_pulse;
  logic [3:0]     current_digit;
  logic [4*N-1:0] entered_code;
  logic [CW-1:0]  digit_count;
  logic           code_full;
  logic           entry_err;
  logic [7*N-1:0] hex_out;

  code_entry_display #(
    .NUM_DIGITS(N), .CNT_W(CW), .BLINK_DIV(25'(BDIV)), .MASK_HOLD(HOLD)
  ) dut (
    .clk(clk), .sys_reset_n(sys_reset_n), .clear_pulse(clear_pulse),
    .store_pulse(store_pulse), .back_pulse(back_pulse), .current_digit(current_digit),
    .entered_code(entered_code), .digit_count(digit_count), .code_full(code_full),
    .entry_err(entry_err), .hex_out(hex_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // reference model
  int digs[$];
  int age;
  int reveal;
  bit model_err;
  int tests;
  int failures;
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    digs.delete();
    age = 0;
    reveal = 0;
    model_err = 0;
  endfunction

  function automatic void model_apply(input bit c, input bit s, input bit b, input int d);
    model_err = 0;
    age++;
    if (reveal > 0) reveal--;
    if (c) begin
      digs.delete();
      age = 0;
      reveal = 0;
    end else if (s) begin
      if (digs.size() < N && d <= 9) begin
        digs.push_back(d);
        age = 0;
        reveal = HOLD;
      end else model_err = 1;
    end else if (b) begin
      if (digs.size() > 0) begin
        void'(digs.pop_back());
        age = 0;
        reveal = 0;
      end else model_err = 1;
    end
  endfunction

  function automatic exp_t model_expected();
    exp_t e;
    logic [6:0] seg;
    bit phase_on;
    phase_on = ((age / BDIV) % 2) == 0;
    e.code = '0;
    e.hex  = '1;
    e.cnt  = CW'(digs.size());
    e.full = (digs.size() == N);
    e.err  = model_err;
    for (int i = 0; i < N; i++) begin
      if (i < digs.size()) begin
        e.code[4*(N-1-i) +: 4] = 4'(digs[i]);
        seg = GLYPH[digs[i]];
`ifdef MASK_DISPLAY_EN
        if (!(i == digs.size() - 1 && reveal > 0)) seg = 7'b0111111;
`endif
      end else if (i == digs.size()) begin
        seg = phase_on ? 7'b1110111 : 7'b1111111;
      end else begin
        seg = 7'b1111111;
      end
      e.hex[7*(N-1-i) +: 7] = seg;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    tests++;
    if (entered_code !== e.code) begin
      failures++;
      $display("FAIL %s entered_code got %h want %h", tag, entered_code, e.code);
    end
    tests++;
    if (digit_count !== e.cnt) begin
      failures++;
      $display("FAIL %s digit_count got %0d want %0d", tag, digit_count, e.cnt);
    end
    tests++;
    if (code_full !== e.full) begin
      failures++;
      $display("FAIL %s code_full got %b want %b", tag, code_full, e.full);
    end
    tests++;
    if (entry_err !== e.err) begin
      failures++;
      $display("FAIL %s entry_err got %b want %b", tag, entry_err, e.err);
    end
    tests++;
    if (hex_out !== e.hex) begin
      failures++;
      $display("FAIL %s hex_out got %b want %b", tag, hex_out, e.hex);
    end
  endtask

  // driver
  task automatic step(input bit c, input bit s, input bit b, input int d);
    clear_pulse   = c;
    store_pulse   = s;
    back_pulse    = b;
    current_digit = 4'(d);
    @(posedge clk);
    model_apply(c, s, b, d);
    exp_q.push_back(model_expected());
    #1;
    clear_pulse = 1'b0;
    store_pulse = 1'b0;
    back_pulse  = 1'b0;
  endtask

  task automatic store(input int d);
    step(0, 1, 0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // monitor: one expected record per clock edge, checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", e);
      end
    end
  end

  initial begin
    tests = 0;
    failures = 0;
    model_reset();
    sys_reset_n   = 1'b0;
    clear_pulse   = 1'b0;
    store_pulse   = 1'b0;
    back_pulse    = 1'b0;
    current_digit = 4'd0;
    #12;
    sys_reset_n = 1'b1;
    #1;
    compare("reset", model_expected());

    // entry, overflow, backspace
    store(3); store(7);
    store(1); store(2); store(9);
    idle(1);
    back_pulse = 1'b0;
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    store(3); store(7); step(0, 0, 1, 0);
    idle(9);
    // priority and invalid digits
    step(1, 1, 0, 5);
    store(12); store(15);
    step(0, 1, 1, 10);
    step(0, 1, 1, 4);
    step(1, 1, 1, 2);
    // reveal window
    store(5); store(6);
    idle(5);
    step(1, 0, 0, 0);

    // asynchronous reset mid-entry
    store(8); store(0); store(4);
    @(negedge clk);
    #1;
    sys_reset_n = 1'b0;
    #1;
    model_reset();
    compare("async_reset", model_expected());
    #1;
    sys_reset_n = 1'b1;

    // random requests
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 11)));
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 6));
    end

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain expected queue got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
